// File: rtl/fifo_push_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter_pkg
// Shared definitions for the FIFO push arbiter:
//   WORD_W     - FIFO word width
//   FIFO_DEPTH - depth of the downstream FIFO
//   state_e    - arbiter FSM states
//   rr_pick    - round-robin winner search starting at a pointer
// -----------------------------------------------------------------------------
package fifo_push_arbiter_pkg;

  localparam int WORD_W     = 45;
  localparam int FIFO_DEPTH = 32;
  localparam int MAX_REQ    = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Returns the first set request bit found searching ptr, ptr+1, ...
  // modulo nreq. Requests are zero-padded to MAX_REQ bits; when no bit is
  // set the pointer itself is returned (the caller qualifies with |req).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int         nreq);
    logic       found;
    int         pos;
    logic [2:0] idx;
    found   = 1'b0;
    rr_pick = ptr;
    for (int k = 0; k < MAX_REQ; k++) begin
      // ptr < nreq and k < nreq, so one conditional subtract is a modulo.
      pos = int'(ptr) + k;
      if (pos >= nreq) begin
        pos = pos - nreq;
      end else begin
        pos = pos;
      end
      idx = 3'(pos);
      if ((k < nreq) && !found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter_rr_picker
// Purely combinational round-robin priority rotate.
// Ports:
//   req    - request vector, one bit per requester
//   ptr    - index that has highest priority this round
//   winner - first requester at or after ptr (valid when any=1)
//   any    - at least one request bit is set
// -----------------------------------------------------------------------------
module fifo_push_arbiter_rr_picker
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            any
);

  logic [7:0] req_pad;
  logic [2:0] ptr_pad;
  logic [2:0] pick;

  // Widen to the package function's fixed argument widths and pick.
  always_comb begin
    req_pad             = 8'h00;
    req_pad[NREQ-1:0]   = req;
    ptr_pad             = 3'(ptr);
    pick                = rr_pick(req_pad, ptr_pad, NREQ);
  end

  assign winner = IDXW'(pick);
  assign any    = |req;

endmodule

// File: rtl/fifo_push_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_push_arbiter
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// One owner is locked for up to MAXBURST words, then ownership rotates
// through a single IDLE cycle. A registered output stage drives the FIFO
// and holds its word while the FIFO reports full.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous reset, active-low
//   pushin    - per-requester word valid
//   din       - per-requester data, requester i at [i*WIDTH +: WIDTH]
//   stopin    - per-requester backpressure (0 = word accepted if pushin=1)
//   pushout   - word valid toward the FIFO
//   dout      - word toward the FIFO
//   full      - FIFO full; a word is consumed when pushout=1 and full=0
//   owner     - current owner index (meaningful while owner_vld=1)
//   owner_vld - 1 while a requester owns the port
// -----------------------------------------------------------------------------
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = WORD_W,
  parameter int MAXBURST = 8,
  parameter int IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       pushin,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       stopin,
  output logic                  pushout,
  output logic [WIDTH-1:0]      dout,
  input  logic                  full,
  output logic [IDXW-1:0]       owner,
  output logic                  owner_vld
);

  state_e           state_q, state_d;
  logic [IDXW-1:0]  owner_q, owner_d;
  logic [IDXW-1:0]  ptr_q, ptr_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic             pushout_q, pushout_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  logic [WIDTH-1:0] din_arr [NREQ];
  logic [IDXW-1:0]  winner;
  logic             any_req;
  logic [IDXW-1:0]  owner_inc;
  logic             out_ready;
  logic             owner_req;
  logic             accept;
  logic             last_word;

  for (genvar g = 0; g < NREQ; g++) begin : g_din
    assign din_arr[g] = din[g*WIDTH +: WIDTH];
  end

  fifo_push_arbiter_rr_picker #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_picker (
    .req    (pushin),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any_req)
  );

  // The output register can take a new word when empty or being drained.
  assign out_ready = !pushout_q || !full;
  assign owner_req = pushin[owner_q];
  assign accept    = (state_q == OWN) && owner_req && out_ready;
  assign last_word = (burst_cnt_q == 8'(MAXBURST - 1));
  assign owner_inc = (owner_q == IDXW'(NREQ - 1)) ? {IDXW{1'b0}}
                                                  : owner_q + IDXW'(1);

  // Backpressure: only the owner is released, and only when the output
  // register can absorb a word this cycle.
  always_comb begin
    stopin = {NREQ{1'b1}};
    if ((state_q == OWN) && out_ready) begin
      stopin[owner_q] = 1'b0;
    end else begin
      stopin = {NREQ{1'b1}};
    end
  end

  // FSM next state, burst counter and output-stage next values.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    pushout_d   = pushout_q;
    dout_d      = dout_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d     = winner;
          burst_cnt_d = 8'd0;
          state_d     = OWN;
        end else begin
          state_d     = IDLE;
        end
      end
      OWN: begin
        if (!owner_req) begin
          // Owner dropped its request: give the next requester priority.
          state_d = IDLE;
          ptr_d   = owner_inc;
        end else if (accept) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
          if (last_word) begin
            state_d = IDLE;
            ptr_d   = owner_inc;
          end else begin
            state_d = OWN;
          end
        end else begin
          // Stalled by a full FIFO: hold ownership and count.
          state_d = OWN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // An accept overwrites the register in the same cycle the old word
    // drains, which gives one word per cycle sustained.
    if (accept) begin
      pushout_d = 1'b1;
      dout_d    = din_arr[owner_q];
    end else if (pushout_q && !full) begin
      pushout_d = 1'b0;
    end else begin
      pushout_d = pushout_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= {IDXW{1'b0}};
      ptr_q       <= {IDXW{1'b0}};
      burst_cnt_q <= 8'd0;
      pushout_q   <= 1'b0;
      dout_q      <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      pushout_q   <= pushout_d;
      dout_q      <= dout_d;
    end
  end

  assign pushout   = pushout_q;
  assign dout      = dout_q;
  assign owner     = owner_q;
  assign owner_vld = (state_q == OWN);

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Round-robin arbiter that shares one 32-deep x 45-bit FIFO write port among NREQ producers.
- Each producer presents a word with a push/stop handshake. The arbiter locks one owner for up to MAXBURST consecutive words, then rotates ownership.
- A registered output stage drives pushout/dout into the FIFO and honours the FIFO's full flag.
- Sits directly upstream of the FIFO in the datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 45, data word width; matches FIFO word width.
- MAXBURST, 8, maximum words accepted per ownership before forced rotation (1..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low (0 = reset).
- pushin  input  NREQ  per-requester word valid.
- din  input  NREQ*WIDTH  per-requester data; requester i occupies bits [i*WIDTH +: WIDTH].
- stopin  output  NREQ  per-requester backpressure; 0 = word accepted this cycle if pushin=1.
- pushout  output  1  word valid toward FIFO.
- dout  output  WIDTH  word toward FIFO.
- full  input  1  FIFO full; the FIFO consumes a word when pushout=1 and full=0.
- owner  output  clog2(NREQ)  current owner index; meaningful only while owner_vld=1.
- owner_vld  output  1  1 in OWN state.

Behaviour:
- Reset (reset=0 at a clk edge): pushout=0, dout=0, stopin=all 1, owner=0, owner_vld=0, rr pointer ptr=0, burst_cnt=0, state=IDLE. Reset mid-burst discards the output-stage word; no word is delivered after reset.
- out_ready = !pushout || !full (combinational).
- Accept for requester i occurs in a cycle where pushin[i]=1 and stopin[i]=0.
- stopin[i]=0 only when state=OWN, i==owner, and out_ready=1; all other requesters see stopin=1.
- FSM states:
  - IDLE: stopin all 1.
    - If any pushin bit is set, winner = first set bit searching ptr, ptr+1, ... modulo NREQ.
    - Next: owner<=winner, burst_cnt<=0, state<=OWN.
    - If no pushin bit is set, stay in IDLE.
  - OWN:
    - On accept: burst_cnt<=burst_cnt+1.
    - Leave to IDLE with ptr<=(owner+1) mod NREQ when either:
      - accept occurs with burst_cnt==MAXBURST-1, or
      - pushin[owner]=0 (owner dropped request; no accept that cycle).
    - Otherwise stay in OWN.
- Grant latency: first word is accepted no earlier than 1 cycle after the request is seen in IDLE.
- Rotation costs one IDLE cycle between owners.
- Output stage:
  - Accept at edge t: dout<=din[owner], pushout=1 from cycle t+1.
  - If pushout=1 and full=0 with no new accept, pushout<=0 and dout holds its value.
  - If pushout=1 and full=1, pushout and dout hold; stopin[owner]=1 (stall).
  - An accept while pushout=1 and full=0 replaces the word back-to-back, giving 1 word/cycle sustained.
- full toggling mid-burst stalls the burst without losing or duplicating words, and does not advance burst_cnt.
- Owner holding pushin with full=1 indefinitely: state remains OWN; no timeout.
- Every accepted word reaches the FIFO exactly once, in per-requester acceptance order.
- burst_cnt is 8 bits wide; it never wraps because it is cleared on every entry to OWN.

Decomposition:
- Shared package holds:
  - WORD_W=45 and FIFO_DEPTH=32 constants;
  - state enum {IDLE, OWN};
  - function rr_pick(req, ptr) returning the winner index.
- One natural sub-module, rr_picker: purely combinational priority rotate.
- FSM, burst counter and output register remain in fifo_push_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with pushin=4'hF → pushout=0, stopin=4'hF, owner_vld=0; release reset → owner=0 on the next cycle.
- Single requester: pushin=4'b0100 with 3 words 45'h1, 45'h2, 45'h3, full=0 → owner=2 after 1 cycle; pushout high for 3 consecutive cycles with dout 1, 2, 3; ptr=3 after requester 2 drops.
- Burst rotation: all 4 requesting continuously, MAXBURST=8, full=0 → ownership order 0, 1, 2, 3, 0; exactly 8 words per owner; one idle cycle between owners.
- Backpressure: owner 1 streaming, full=1 for 5 cycles mid-burst → pushout and dout held stable; stopin[1]=1; no loss or duplicates; burst resumes when full=0.
- Pointer wrap: ptr=3, requests on 0 and 2 only → requester 0 wins.
- Reset mid-burst: assert reset while pushout=1 → pushout=0 on the next edge; subsequent arbitration restarts from requester 0.
